// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage of a pipelined RV32 core.
// Latency: loads return combinationally in the access cycle; stores, the error record and the counters update at the next rising edge.
// Backpressure: none. Every request is accepted in its cycle, and an illegal request is dropped and recorded as an error.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   mem_w, mem_r        store / load request from EX/MEM
//   addr, wdata         byte address and right-justified store data
//   dm_type             000 word, 001 half, 010 half-u, 011 byte, 100 byte-u
//   rdata               aligned and extended load data (0 when no legal load)
//   dbg_addr, dbg_data  raw word read port for the board wrapper
//   err, err_addr, err_code   sticky record of the first faulting access
//   wr_cnt, rd_cnt      committed store / legal load counters (wrapping)
module dmem_responder #(
    parameter int          ADDR_WIDTH = 7,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_w,
    input  logic                  mem_r,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic [2:0]            dm_type,
    output logic [31:0]           rdata,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [31:0]           dbg_data,
    output logic                  err,
    output logic [31:0]           err_addr,
    output logic [1:0]            err_code,
    output logic [31:0]           wr_cnt,
    output logic [31:0]           rd_cnt
);

    localparam int          DEPTH       = 1 << ADDR_WIDTH;
    // Byte size of the array. It is held in 33 bits so that the range compare
    // cannot overflow even for the widest legal ADDR_WIDTH.
    localparam logic [32:0] DEPTH_BYTES = 33'd4 << ADDR_WIDTH;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    localparam logic [1:0] EC_NONE     = 2'b00;
    localparam logic [1:0] EC_MISALIGN = 2'b01;
    localparam logic [1:0] EC_RANGE    = 2'b10;
    localparam logic [1:0] EC_ILLEGAL  = 2'b11;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            bl;
    logic                  access;
    logic                  in_range;
    logic                  type_ok;
    logic                  align_ok;
    logic [1:0]            fault_code;
    logic                  legal;
    logic [31:0]           word;
    logic [3:0]            be;
    logic [31:0]           wd;

    logic        err_q,      err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] wr_cnt_q,   wr_cnt_d;
    logic [31:0] rd_cnt_q,   rd_cnt_d;

    assign off    = addr - BASE_ADDR;
    assign idx    = off[ADDR_WIDTH+1:2];
    assign bl     = off[1:0];
    assign access = mem_w | mem_r;

    // An address below BASE_ADDR wraps to a huge offset. The explicit compare
    // against BASE_ADDR rejects it regardless of the array size.
    assign in_range = (addr >= BASE_ADDR) && ({1'b0, off} < DEPTH_BYTES);
    assign type_ok  = (dm_type <= DM_BYTE_U);

    always_comb begin
        align_ok = 1'b1;
        case (dm_type)
            DM_WORD:            align_ok = (bl == 2'b00);
            DM_HALF, DM_HALF_U: align_ok = ~bl[0];
            default:            align_ok = 1'b1;
        endcase
    end

    // Priority of causes: illegal type or a simultaneous read and write, then
    // out of range, then misaligned.
    always_comb begin
        fault_code = EC_NONE;
        if (!type_ok || (mem_w && mem_r)) begin
            fault_code = EC_ILLEGAL;
        end else if (!in_range) begin
            fault_code = EC_RANGE;
        end else if (!align_ok) begin
            fault_code = EC_MISALIGN;
        end
    end

    assign legal = access && (fault_code == EC_NONE);
    assign word  = mem_q[idx];

    // Load path: select the lane and extend it in the access cycle.
    always_comb begin
        rdata = 32'h0;
        if (mem_r && legal) begin
            case (dm_type)
                DM_WORD:   rdata = word;
                DM_HALF:   rdata = bl[1] ? {{16{word[31]}}, word[31:16]}
                                         : {{16{word[15]}}, word[15:0]};
                DM_HALF_U: rdata = bl[1] ? {16'h0, word[31:16]}
                                         : {16'h0, word[15:0]};
                DM_BYTE:   rdata = {{24{word[8*bl+7]}}, word[8*bl +: 8]};
                DM_BYTE_U: rdata = {24'h0, word[8*bl +: 8]};
                default:   rdata = 32'h0;
            endcase
        end
    end

    // Store lanes. The data is replicated across the word so that each enabled
    // lane picks up the right bytes from the same vector.
    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (dm_type)
            DM_WORD: begin
                be = 4'b1111;
                wd = wdata;
            end
            DM_HALF, DM_HALF_U: begin
                be = bl[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            DM_BYTE, DM_BYTE_U: begin
                be = 4'b0001 << bl;
                wd = {4{wdata[7:0]}};
            end
            default: begin
                be = 4'b0000;
                wd = wdata;
            end
        endcase
    end

    // The array is deliberately left out of reset. Its contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_w && legal) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    assign dbg_data = mem_q[dbg_addr];

    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        err_code_d = err_code_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        // Only the first fault is recorded. Later faults leave the record alone.
        if (access && !legal && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr;
            err_code_d = fault_code;
        end
        if (mem_w && legal) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (mem_r && legal) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
            err_code_q <= EC_NONE;
            wr_cnt_q   <= 32'h0;
            rd_cnt_q   <= 32'h0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_code_q <= err_code_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign err_code = err_code_q;
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;

endmodule
